// File: rtl/data_memory_responder.sv
// Fixed-latency word memory behind a load/store request port.
// Single outstanding request: IDLE captures, WAIT counts down, RESP pulses mem_ack.
module data_memory_responder #(
   parameter int unsigned MEM_WORDS = 256,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   output logic        mem_ack,
   output logic [31:0] mem_read_val,
   output logic        mem_err,
   output logic        busy
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam logic [3:0] LatInit = 4'(LATENCY - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        req_we_q, req_we_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] req_data_q, req_data_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_q [MEM_WORDS];

   logic          wr_en;
   logic [AW-1:0] word_idx;
   logic          in_range;
   logic          unused_addr_bits;

   assign word_idx         = req_addr_q[AW+1:2];
   assign in_range         = (req_addr_q[31:AW+2] == '0);
   assign unused_addr_bits = ^req_addr_q[1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_we_d   = req_we_q;
      req_addr_d = req_addr_q;
      req_data_d = req_data_q;
      rdata_d    = rdata_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      wr_en      = 1'b0;
      case (state_q)
         StIdle: begin
            if (mem_req) begin
               req_we_d   = mem_we;
               req_addr_d = mem_addr;
               req_data_d = mem_data;
               cnt_d      = LatInit;
               state_d    = StWait;
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               // Access happens on the edge into RESP so every output is registered.
               state_d = StResp;
               ack_d   = 1'b1;
               err_d   = ~in_range;
               if (req_we_q) begin
                  wr_en   = in_range;
                  rdata_d = '0;
               end else begin
                  rdata_d = in_range ? mem_q[word_idx] : '0;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         req_we_q   <= 1'b0;
         req_addr_q <= '0;
         req_data_q <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         rdata_q    <= '0;
         for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_we_q   <= req_we_d;
         req_addr_q <= req_addr_d;
         req_data_q <= req_data_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         rdata_q    <= rdata_d;
         if (wr_en) begin
            mem_q[word_idx] <= req_data_q;
         end
      end
   end

   assign mem_ack      = ack_q;
   assign mem_err      = err_q;
   assign busy         = busy_q;
   assign mem_read_val = rdata_q;

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL provide parameter MEM_WORDS, default 256, memory depth in 32-bit words (power of two).
REQ-002 SHALL provide parameter LATENCY, default 2, cycles from request capture to mem_ack (legal range 1..15).
REQ-003 SHALL provide port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port mem_req  input  1  request valid from the load/store queue.
REQ-006 SHALL provide port mem_we  input  1  1 = store, 0 = load.
REQ-007 SHALL provide port mem_addr  input  32  byte address.
REQ-008 SHALL provide port mem_data  input  32  store data.
REQ-009 SHALL provide port mem_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL provide port mem_read_val  output  32  load result, valid while mem_ack=1.
REQ-011 SHALL provide port mem_err  output  1  one-cycle pulse with mem_ack when the address was out of range.
REQ-012 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-014 IDLE: on an edge with mem_req=1, SHALL latch mem_we, mem_addr, mem_data into request registers, load wait counter with LATENCY-1, go to WAIT.
REQ-015 WAIT: counter decrements each edge; at counter=0 SHALL go to RESP on that edge (LATENCY=1: WAIT lasts one cycle).
REQ-016 On the WAIT->RESP edge, SHALL perform the access: word index = latched addr[log2(MEM_WORDS)+1:2]; addr[1:0] ignored.
REQ-017 In range = latched addr[31:log2(MEM_WORDS)+2] all zero; else out of range.
REQ-018 In-range store SHALL write latched data; in-range load SHALL register word into mem_read_val.
REQ-019 Out-of-range store SHALL be dropped; out-of-range load SHALL return 0; mem_err SHALL be 1 in RESP.
REQ-020 Store completion SHALL drive mem_read_val = 0.
REQ-021 RESP SHALL last exactly one cycle with mem_ack=1, then SHALL return to IDLE; mem_ack and mem_err 0 in all other states.
REQ-022 Total latency: request captured at edge N, mem_ack high during cycle after edge N+LATENCY.
REQ-023 mem_req and request inputs SHALL be ignored in WAIT and RESP; the latched request completes unchanged even if inputs change or mem_req drops.
REQ-024 A request held continuously SHALL be re-captured in IDLE after RESP; requester must drop or change mem_req on seeing mem_ack.
REQ-025 mem_read_val SHALL hold its last value outside RESP until the next completion.
REQ-026 Store then load to same word: load SHALL return the stored data (write committed before the load is captured).

Reset
REQ-027 On rst_n=1, SHALL go to IDLE immediately; mem_ack=0, mem_err=0, busy=0, mem_read_val=0, counter=0, request registers=0.
REQ-028 Reset SHALL clear all memory words to 0.
REQ-029 Reset during WAIT SHALL abort the pending request: no write, no ack after release.
REQ-030 First request SHALL be captured on the first edge after rst_n deasserts with mem_req=1.

Verification
REQ-031 Store 0xDEADBEEF to 0x10, LATENCY=2 -> mem_ack pulse 2 cycles after capture, mem_read_val=0; then load 0x10 -> mem_read_val=0xDEADBEEF with mem_ack.
REQ-032 Load 0x13 after storing 0x12345678 at 0x10 -> returns 0x12345678 (low bits ignored).
REQ-033 Load 0x400 (MEM_WORDS=256) -> mem_ack=1, mem_err=1, mem_read_val=0; store 0x400 then load 0x0 -> 0 returned.
REQ-034 Change mem_addr 0x20->0x24 during WAIT -> response reflects 0x20; busy=1 throughout WAIT/RESP.
REQ-035 Assert rst_n mid-WAIT of store to 0x8 -> no mem_ack; subsequent load 0x8 -> 0.
REQ-036 LATENCY=1, mem_req held high 10 cycles -> mem_ack every 3 cycles (IDLE, WAIT, RESP).
